// File: rtl/mpt_pkg.sv
// Shared MPT walker types: physical address width, entry width and the
// response bundle carried through the memory responder delay line.
package mpt_pkg;

    localparam int PLEN          = 56;
    localparam int MPT_ENTRY_LEN = 64;

    typedef struct packed {
        logic                     valid;
        logic                     err;
        logic [MPT_ENTRY_LEN-1:0] data;
    } mpt_mem_rsp_t;

endpackage

// File: rtl/mpt_mem_responder_if.sv
// Walker memory port: single-word read request with a grant, and an
// in-order valid/data/error response with no backpressure.
interface mpt_mem_responder_if;
    import mpt_pkg::*;

    logic                     mem_req_i;
    logic [PLEN-1:0]          mem_addr_i;
    logic                     mem_gnt_o;
    logic                     mem_valid_o;
    logic [MPT_ENTRY_LEN-1:0] mem_rdata_o;
    logic                     mem_err_o;

    modport master (
        output mem_req_i,
        output mem_addr_i,
        input  mem_gnt_o,
        input  mem_valid_o,
        input  mem_rdata_o,
        input  mem_err_o
    );

    modport slave (
        input  mem_req_i,
        input  mem_addr_i,
        output mem_gnt_o,
        output mem_valid_o,
        output mem_rdata_o,
        output mem_err_o
    );

endinterface

// File: rtl/mpt_mem_delay_line.sv
// Fixed-latency shift pipeline of responses; a flush empties every stage
// on the next edge, reset empties them immediately.
module mpt_mem_delay_line
    import mpt_pkg::*;
#(
    parameter int unsigned LATENCY = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  mpt_mem_rsp_t rsp_i,
    output mpt_mem_rsp_t rsp_o
);

    mpt_mem_rsp_t stage_q [LATENCY];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                stage_q[i] <= '0;
            end
        end else if (flush_i) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= rsp_i;
            for (int i = 1; i < int'(LATENCY); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign rsp_o = stage_q[LATENCY-1];

endmodule

// File: rtl/mpt_mem_responder.sv
// Table backing store for the MPT walker: decodes and reads at accept,
// then returns the entry (or an error) a fixed number of cycles later.
module mpt_mem_responder
    import mpt_pkg::*;
#(
    parameter int unsigned     DEPTH_WORDS     = 1024,
    parameter logic [PLEN-1:0] BASE_ADDR       = '0,
    parameter int unsigned     LATENCY         = 2,
    parameter int unsigned     MAX_OUTSTANDING = 2,
    localparam int             IDX_W           = $clog2(DEPTH_WORDS)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    mpt_mem_responder_if.slave       mem,
    input  logic                     wr_en_i,
    input  logic [IDX_W-1:0]         wr_idx_i,
    input  logic [MPT_ENTRY_LEN-1:0] wr_data_i
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [MPT_ENTRY_LEN-1:0] table_q [DEPTH_WORDS];

    logic [CNT_W-1:0] inflight_q;
    logic [CNT_W-1:0] inflight_d;
    logic             accept;
    logic             misaligned;
    logic             below;
    logic             out_of_range;
    logic [PLEN-1:0]  offset;
    logic [PLEN-4:0]  word;
    logic [IDX_W-1:0] idx;
    mpt_mem_rsp_t     req_rsp;
    mpt_mem_rsp_t     out_rsp;

    assign mem.mem_gnt_o = ((inflight_q < CNT_W'(MAX_OUTSTANDING)) || out_rsp.valid)
                           && !flush_i;
    assign accept        = mem.mem_req_i && mem.mem_gnt_o;

    // BASE_ADDR is 8-byte aligned, so the offset's low bits are the address's
    assign offset       = mem.mem_addr_i - BASE_ADDR;
    assign word         = offset[PLEN-1:3];
    assign idx          = word[IDX_W-1:0];
    assign misaligned   = |offset[2:0];
    assign below        = mem.mem_addr_i < BASE_ADDR;
    assign out_of_range = below || (word >= (PLEN-3)'(DEPTH_WORDS));

    always_comb begin
        req_rsp = '0;
        if (accept) begin
            req_rsp.valid = 1'b1;
            req_rsp.err   = misaligned || out_of_range;
            if (!(misaligned || out_of_range)) begin
                req_rsp.data = table_q[idx];
            end
        end
    end

    // Backdoor preload port; contents survive reset and flush
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            table_q[wr_idx_i] <= wr_data_i;
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        if (flush_i) begin
            inflight_d = '0;
        end else if (accept && !out_rsp.valid) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!accept && out_rsp.valid) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    mpt_mem_delay_line #(
        .LATENCY (LATENCY)
    ) u_delay (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .rsp_i   (req_rsp),
        .rsp_o   (out_rsp)
    );

    assign mem.mem_valid_o = out_rsp.valid;
    assign mem.mem_err_o   = out_rsp.err;
    assign mem.mem_rdata_o = out_rsp.data;

endmodule
